// File: rtl/core_seq_pkg.sv
// core_seq_pkg
//    Shared definitions for the core instruction sequencer: array and memory
//    geometry, bit positions of the 35-bit core instruction word, the idle
//    instruction value and the sequencer state encoding.
//    Optional build macro used by the sequencer: CORE_SEQ_PERF_EN.
package core_seq_pkg;

   localparam int ROW     = 8;     // array rows, weight words per kij
   localparam int COL     = 8;     // array columns
   localparam int ADDR_BW = 11;    // SRAM address width (2048 words)
   localparam int KIJ_MAX = 9;     // kernel positions per run
   localparam int INST_W  = 35;
   localparam int CNT_W   = ADDR_BW + 1;  // holds L+row+col-1 for any L

   // instruction word bit positions
   localparam int B_L0_RD    = 0;
   localparam int B_L0_WR    = 1;
   localparam int B_OFIFO_RD = 2;
   localparam int B_IFIFO_WR = 3;
   localparam int B_IFIFO_RD = 4;
   localparam int B_EXECUTE  = 5;
   localparam int B_LOAD     = 6;
   localparam int B_XA_LO    = 7;
   localparam int B_XA_HI    = 17;
   localparam int B_XMEM_WEN = 18;
   localparam int B_XMEM_CEN = 19;
   localparam int B_PA_LO    = 20;
   localparam int B_PA_HI    = 30;
   localparam int B_PMEM_WEN = 31;
   localparam int B_PMEM_CEN = 32;
   localparam int B_ACC      = 33;
   localparam int B_RELU     = 34;

   // both SRAMs disabled (active-low CEN/WEN high), every strobe low
   localparam logic [INST_W-1:0] IDLE_INST = 35'h1_800C_0000;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WLOAD,
      S_KPROP,
      S_XLOAD,
      S_EXEC,
      S_DRAIN,
      S_NEXT,
      S_ACC,
      S_DONE
   } state_t;

endpackage

// File: rtl/core_seq_ctrl_addr_gen.sv
// core_seq_addr_gen
//    Address generator shared by the weight/activation loads, the psum drain
//    and the accumulate pass. All arithmetic is modulo 2^ADDR_BW.
//    xmem layout per kij: ROW weight words followed by num_act activations,
//    so the kij region starts at xmem_base + kij*(ROW+num_act).
//    pmem layout: num_act psum words per kij starting at pmem_base + kij*num_act.
//    Ports:
//       xmem_base, pmem_base, num_act : sampled run configuration
//       x_kij, x_off                  : kij and word offset inside the xmem region
//       p_kij, p_off                  : kij and output index inside the pmem region
//       xmem_addr, pmem_addr          : resulting SRAM addresses
module core_seq_addr_gen
   import core_seq_pkg::*;
(
   input  logic [ADDR_BW-1:0] xmem_base,
   input  logic [ADDR_BW-1:0] pmem_base,
   input  logic [ADDR_BW-1:0] num_act,
   input  logic [3:0]         x_kij,
   input  logic [ADDR_BW-1:0] x_off,
   input  logic [3:0]         p_kij,
   input  logic [ADDR_BW-1:0] p_off,
   output logic [ADDR_BW-1:0] xmem_addr,
   output logic [ADDR_BW-1:0] pmem_addr
);

   logic [ADDR_BW-1:0] x_stride;

   assign x_stride  = ADDR_BW'(ROW) + num_act;
   // products truncate to ADDR_BW bits, giving silent wrap-around
   assign xmem_addr = xmem_base + ADDR_BW'(x_kij) * x_stride + x_off;
   assign pmem_addr = pmem_base + ADDR_BW'(p_kij) * num_act + p_off;

endmodule

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl
//    Instruction sequencer that steps the input SRAM, psum SRAM and corelet
//    through one convolution tile: per kij it loads weights, propagates the
//    kernel, loads and executes activations and drains the output FIFO into
//    psum memory; after the last kij it runs an accumulate/readout pass.
//    Optional build macro: CORE_SEQ_PERF_EN adds cycle_cnt / stall_cnt.
//    Ports:
//       clk, reset (synchronous, active low)
//       start          : one-cycle pulse, accepted only in IDLE
//       cfg_*          : run configuration, sampled on an accepted start
//       ofifo_valid    : output FIFO holds a complete row
//       inst           : 35-bit instruction word to the core (registered)
//       busy           : high while running (registered)
//       cycle_cnt      : busy cycles of the last run   (CORE_SEQ_PERF_EN)
//       stall_cnt      : DRAIN cycles without data     (CORE_SEQ_PERF_EN)
//       done           : one-cycle pulse at the end of a run
//    All outputs are registered from the current state, so the word for a
//    state appears one cycle after the state is entered.
//    The accumulate pass reads every kij for each output index in turn
//    (outer loop output index, inner loop kij), num_kij*L cycles, with relu
//    raised on the read of the last kij of each index.
module core_seq_ctrl
   import core_seq_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [3:0]          cfg_num_kij,
   input  logic [ADDR_BW-1:0]  cfg_num_act,
   input  logic [ADDR_BW-1:0]  cfg_xmem_base,
   input  logic [ADDR_BW-1:0]  cfg_pmem_base,
   input  logic                ofifo_valid,
   output logic [INST_W-1:0]   inst,
   output logic                busy,
`ifdef CORE_SEQ_PERF_EN
   output logic [31:0]         cycle_cnt,
   output logic [15:0]         stall_cnt,
`endif
   output logic                done
);

   state_t               state_reg;
   logic [3:0]           k_reg;          // current kij
   logic [3:0]           acc_k_reg;      // kij inside the accumulate pass
   logic [3:0]           num_kij_reg;
   logic [ADDR_BW-1:0]   num_act_reg;
   logic [ADDR_BW-1:0]   xmem_base_reg;
   logic [ADDR_BW-1:0]   pmem_base_reg;
   logic [ADDR_BW-1:0]   j_reg;          // psum write / output index
   logic [CNT_W-1:0]     cnt_reg;        // cycle count inside timed states

   logic [CNT_W-1:0]     xload_last;
   logic [CNT_W-1:0]     exec_last;
   logic                 j_last;
   logic                 kij_last;
   logic                 acc_last;
   logic [ADDR_BW-1:0]   x_off;
   logic [3:0]           p_kij;
   logic [ADDR_BW-1:0]   xmem_addr;
   logic [ADDR_BW-1:0]   pmem_addr;
   logic [INST_W-1:0]    inst_next;

   assign xload_last = {1'b0, num_act_reg} - CNT_W'(1);
   assign exec_last  = {1'b0, num_act_reg} + CNT_W'(ROW + COL - 1);
   assign j_last     = (j_reg == num_act_reg - ADDR_BW'(1));
   assign kij_last   = (k_reg == num_kij_reg - 4'd1);
   assign acc_last   = (acc_k_reg == num_kij_reg - 4'd1);

   // activations sit after the ROW weight words of the same kij
   assign x_off = (state_reg == S_XLOAD) ? ADDR_BW'(ROW) + cnt_reg[ADDR_BW-1:0]
                                         : cnt_reg[ADDR_BW-1:0];
   assign p_kij = (state_reg == S_ACC) ? acc_k_reg : k_reg;

   core_seq_addr_gen u_addr_gen (
      .xmem_base (xmem_base_reg),
      .pmem_base (pmem_base_reg),
      .num_act   (num_act_reg),
      .x_kij     (k_reg),
      .x_off     (x_off),
      .p_kij     (p_kij),
      .p_off     (j_reg),
      .xmem_addr (xmem_addr),
      .pmem_addr (pmem_addr)
   );

   // Instruction word for the current state. The SRAM has one cycle of
   // read latency, so l0_wr follows whatever xmem read is on inst now.
   always_comb begin
      inst_next          = IDLE_INST;
      inst_next[B_L0_WR] = ~inst[B_XMEM_CEN];
      case (state_reg)
         S_WLOAD, S_XLOAD: begin
            inst_next[B_XMEM_CEN]       = 1'b0;
            inst_next[B_XA_HI:B_XA_LO]  = xmem_addr;
         end
         S_KPROP: begin
            inst_next[B_L0_RD] = 1'b1;
            inst_next[B_LOAD]  = 1'b1;
         end
         S_EXEC: begin
            inst_next[B_L0_RD]   = 1'b1;
            inst_next[B_EXECUTE] = 1'b1;
         end
         S_DRAIN: begin
            if (ofifo_valid) begin
               inst_next[B_OFIFO_RD]      = 1'b1;
               inst_next[B_PMEM_CEN]      = 1'b0;
               inst_next[B_PMEM_WEN]      = 1'b0;
               inst_next[B_PA_HI:B_PA_LO] = pmem_addr;
            end
         end
         S_ACC: begin
            inst_next[B_PMEM_CEN]      = 1'b0;
            inst_next[B_PA_HI:B_PA_LO] = pmem_addr;
            inst_next[B_ACC]           = 1'b1;
            inst_next[B_RELU]          = acc_last;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg     <= S_IDLE;
         inst          <= IDLE_INST;
         busy          <= 1'b0;
         done          <= 1'b0;
         k_reg         <= '0;
         acc_k_reg     <= '0;
         num_kij_reg   <= '0;
         num_act_reg   <= '0;
         xmem_base_reg <= '0;
         pmem_base_reg <= '0;
         j_reg         <= '0;
         cnt_reg       <= '0;
`ifdef CORE_SEQ_PERF_EN
         cycle_cnt     <= '0;
         stall_cnt     <= '0;
`endif
      end else begin
         inst <= inst_next;
         busy <= (state_reg != S_IDLE) && (state_reg != S_DONE);
         done <= (state_reg == S_DONE);

`ifdef CORE_SEQ_PERF_EN
         if (state_reg == S_IDLE && start) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
         end else begin
            if (busy)
               cycle_cnt <= cycle_cnt + 32'd1;
            if (state_reg == S_DRAIN && !ofifo_valid)
               stall_cnt <= stall_cnt + 16'd1;
         end
`endif

         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  // zero counts mean one; more kij than the array supports is clamped
                  if (cfg_num_kij == 4'd0)
                     num_kij_reg <= 4'd1;
                  else if (cfg_num_kij > 4'(KIJ_MAX))
                     num_kij_reg <= 4'(KIJ_MAX);
                  else
                     num_kij_reg <= cfg_num_kij;
                  num_act_reg   <= (cfg_num_act == '0) ? ADDR_BW'(1) : cfg_num_act;
                  xmem_base_reg <= cfg_xmem_base;
                  pmem_base_reg <= cfg_pmem_base;
                  k_reg         <= '0;
                  cnt_reg       <= '0;
                  state_reg     <= S_WLOAD;
               end
            end
            S_WLOAD: begin
               if (cnt_reg == CNT_W'(ROW - 1)) begin
                  cnt_reg   <= '0;
                  state_reg <= S_KPROP;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            S_KPROP: begin
               if (cnt_reg == CNT_W'(ROW + COL - 1)) begin
                  cnt_reg   <= '0;
                  state_reg <= S_XLOAD;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            S_XLOAD: begin
               if (cnt_reg == xload_last) begin
                  cnt_reg   <= '0;
                  state_reg <= S_EXEC;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            S_EXEC: begin
               if (cnt_reg == exec_last) begin
                  cnt_reg   <= '0;
                  j_reg     <= '0;
                  state_reg <= S_DRAIN;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            S_DRAIN: begin
               // no timeout: an empty FIFO simply stalls the drain
               if (ofifo_valid) begin
                  if (j_last) begin
                     j_reg     <= '0;
                     state_reg <= S_NEXT;
                  end else begin
                     j_reg <= j_reg + ADDR_BW'(1);
                  end
               end
            end
            S_NEXT: begin
               if (kij_last) begin
                  j_reg     <= '0;
                  acc_k_reg <= '0;
                  state_reg <= S_ACC;
               end else begin
                  k_reg     <= k_reg + 4'd1;
                  state_reg <= S_WLOAD;
               end
            end
            S_ACC: begin
               if (acc_last) begin
                  acc_k_reg <= '0;
                  if (j_last) begin
                     j_reg     <= '0;
                     state_reg <= S_DONE;
                  end else begin
                     j_reg <= j_reg + ADDR_BW'(1);
                  end
               end else begin
                  acc_k_reg <= acc_k_reg + 4'd1;
               end
            end
            S_DONE: begin
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl
//    Self-checking bench for core_seq_ctrl. For every run a reference trace of
//    the expected (inst, busy, done) per cycle is built from the sequencing
//    rules with plain loops, then compared cycle by cycle against the DUT.
//    A few hand-computed expectations (addresses, busy length, done width)
//    pin the reference itself. Optional macro: CORE_SEQ_PERF_EN.
module tb_core_seq_ctrl;

   localparam logic [34:0] IDLE_W = 35'h1_800C_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  cfg_num_kij = '0;
   logic [10:0] cfg_num_act = '0;
   logic [10:0] cfg_xmem_base = '0;
   logic [10:0] cfg_pmem_base = '0;
   logic        ofifo_valid = 1'b0;
   logic [34:0] inst;
   logic        busy;
   logic        done;
`ifdef CORE_SEQ_PERF_EN
   logic [31:0] cycle_cnt;
   logic [15:0] stall_cnt;
`endif

   core_seq_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .cfg_num_kij   (cfg_num_kij),
      .cfg_num_act   (cfg_num_act),
      .cfg_xmem_base (cfg_xmem_base),
      .cfg_pmem_base (cfg_pmem_base),
      .ofifo_valid   (ofifo_valid),
      .inst          (inst),
      .busy          (busy),
`ifdef CORE_SEQ_PERF_EN
      .cycle_cnt     (cycle_cnt),
      .stall_cnt     (stall_cnt),
`endif
      .done          (done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // reference trace, entry n = outputs after the n-th edge following start
   logic [34:0] exp_inst[$];
   bit          exp_busy[$];
   bit          exp_done[$];
   bit          exp_rd[$];
   bit          valid_at[4096];   // ofifo_valid seen at edge n of a run

   // observations of the last run
   int          xr_addr[$];
   int          pw_addr[$];
   int          busy_cycles;
   int          done_cycles;

   function automatic logic [34:0] w_xread(input int a);
      logic [34:0] w;
      logic [10:0] a11;
      a11      = 11'(a % 2048);
      w        = IDLE_W;
      w[19]    = 1'b0;
      w[17:7]  = a11;
      return w;
   endfunction

   function automatic logic [34:0] w_pwrite(input int a);
      logic [34:0] w;
      logic [10:0] a11;
      a11      = 11'(a % 2048);
      w        = IDLE_W;
      w[32]    = 1'b0;
      w[31]    = 1'b0;
      w[30:20] = a11;
      w[2]     = 1'b1;
      return w;
   endfunction

   function automatic logic [34:0] w_pread(input int a, input bit last);
      logic [34:0] w;
      logic [10:0] a11;
      a11      = 11'(a % 2048);
      w        = IDLE_W;
      w[32]    = 1'b0;
      w[30:20] = a11;
      w[33]    = 1'b1;
      w[34]    = last;
      return w;
   endfunction

   task automatic push(input logic [34:0] w, input bit b, input bit d, input bit rd);
      exp_inst.push_back(w);
      exp_busy.push_back(b);
      exp_done.push_back(d);
      exp_rd.push_back(rd);
   endtask

   task automatic build_trace(input int kij_raw, input int l_raw, input int xb, input int pb);
      int nk;
      int l;
      int w;
      logic [34:0] t;
      nk = (kij_raw == 0) ? 1 : kij_raw;
      l  = (l_raw == 0) ? 1 : l_raw;
      exp_inst.delete(); exp_busy.delete(); exp_done.delete(); exp_rd.delete();
      push(IDLE_W, 0, 0, 0);                                   // start edge, still idle
      for (int k = 0; k < nk; k++) begin
         for (int i = 0; i < 8; i++) push(w_xread(xb + k * (8 + l) + i), 1, 0, 1);
         for (int i = 0; i < 16; i++) push(IDLE_W | 35'h41, 1, 0, 0);
         for (int i = 0; i < l; i++) push(w_xread(xb + k * (8 + l) + 8 + i), 1, 0, 1);
         for (int i = 0; i < l + 16; i++) push(IDLE_W | 35'h21, 1, 0, 0);
         w = 0;
         while (w < l) begin
            if (valid_at[exp_inst.size()]) begin
               push(w_pwrite(pb + k * l + w), 1, 0, 0);
               w++;
            end else begin
               push(IDLE_W, 1, 0, 0);
            end
         end
         push(IDLE_W, 1, 0, 0);                                // kij bookkeeping cycle
      end
      for (int j = 0; j < l; j++)
         for (int k = 0; k < nk; k++)
            push(w_pread(pb + k * l + j, k == nk - 1), 1, 0, 0);
      push(IDLE_W, 0, 1, 0);                                   // done pulse
      push(IDLE_W, 0, 0, 0);
      // each xmem read is written into L0 one cycle later
      for (int n = 1; n < exp_inst.size(); n++) begin
         if (exp_rd[n - 1]) begin
            t = exp_inst[n];
            t[1] = 1'b1;
            exp_inst[n] = t;
         end
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
      end
   endtask

   task automatic fill_valid(input int pct);
      for (int i = 0; i < 4096; i++) valid_at[i] = ($urandom_range(0, 99) < pct);
   endtask

   // mode 0: plain run, 1: extra start with new cfg mid-run, 2: reset abort at EXEC
   task automatic run(input string tag, input int nk, input int l, input int xb,
                      input int pb, input int mode);
      int dcount;
      build_trace(nk, l, xb, pb);
      xr_addr.delete(); pw_addr.delete();
      busy_cycles = 0; done_cycles = 0;
      @(negedge clk);
      cfg_num_kij   = 4'(nk);
      cfg_num_act   = 11'(l);
      cfg_xmem_base = 11'(xb);
      cfg_pmem_base = 11'(pb);
      start         = 1'b1;
      ofifo_valid   = valid_at[0];
      @(posedge clk);
      for (int n = 0; n < exp_inst.size(); n++) begin
         @(negedge clk);
         tests++;
         if (inst !== exp_inst[n] || busy !== exp_busy[n] || done !== exp_done[n]) begin
            fails++;
            $display("FAIL %s cycle %0d: inst=%h busy=%b done=%b, expected inst=%h busy=%b done=%b",
                     tag, n, inst, busy, done, exp_inst[n], exp_busy[n], exp_done[n]);
         end
         if (inst[19] === 1'b0) xr_addr.push_back(int'(inst[17:7]));
         if (inst[32] === 1'b0 && inst[31] === 1'b0) pw_addr.push_back(int'(inst[30:20]));
         if (busy === 1'b1) busy_cycles++;
         if (done === 1'b1) done_cycles++;
         start       = 1'b0;
         ofifo_valid = valid_at[n + 1];
         if (mode == 1 && n == 20) begin
            start         = 1'b1;
            cfg_num_kij   = 4'($urandom_range(1, 9));
            cfg_num_act   = 11'($urandom_range(1, 2047));
            cfg_xmem_base = 11'($urandom_range(0, 2047));
            cfg_pmem_base = 11'($urandom_range(0, 2047));
         end
         if (mode == 2 && n == 35) begin
            reset = 1'b0;
            break;
         end
      end
      if (mode == 2) begin
         @(posedge clk);
         @(negedge clk);
         reset = 1'b1;
         check("abort_inst", inst, IDLE_W);
         check("abort_busy", busy, 0);
         dcount = 0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) dcount++;
         end
         check("abort_no_done", dcount, 0);
      end
      $display("[TB] run %s kij=%0d L=%0d xb=%0d pb=%0d cycles=%0d busy=%0d", tag, nk, l, xb, pb,
               exp_inst.size(), busy_cycles);
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      check("reset_inst", inst, IDLE_W);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      reset = 1'b1;

      // one kij, L=4, FIFO always ready
      fill_valid(100);
      run("basic", 1, 4, 0, 0, 0);
      check("basic_xreads", xr_addr.size(), 12);
      for (int i = 0; i < 12 && i < xr_addr.size(); i++) check("basic_xaddr", xr_addr[i], i);
      check("basic_pwrites", pw_addr.size(), 4);
      for (int i = 0; i < 4 && i < pw_addr.size(); i++) check("basic_paddr", pw_addr[i], i);
      check("basic_done_width", done_cycles, 1);
      check("basic_busy_len", busy_cycles, 57);
`ifdef CORE_SEQ_PERF_EN
      check("basic_cycle_cnt", cycle_cnt, 57);
      check("basic_stall_cnt", stall_cnt, 0);
`endif

      // three kij, kij 2 region starts at 100 + 2*(8+2) = 120
      run("kij3", 3, 2, 100, 0, 0);
      check("kij3_xreads", xr_addr.size(), 30);
      for (int i = 0; i < 8 && 20 + i < xr_addr.size(); i++) check("kij3_wload2", xr_addr[20 + i], 120 + i);
      check("kij3_pwrites", pw_addr.size(), 6);
      if (pw_addr.size() >= 6) begin
         check("kij3_paddr4", pw_addr[4], 4);
         check("kij3_paddr5", pw_addr[5], 5);
      end

      // drain sees valid 1,0,0,1 starting at its first cycle (edge 45 for L=2)
      valid_at[45] = 1'b1; valid_at[46] = 1'b0; valid_at[47] = 1'b0; valid_at[48] = 1'b1;
      run("stall", 1, 2, 0, 0, 0);
      check("stall_pwrites", pw_addr.size(), 2);
      check("stall_busy_len", busy_cycles, 51);
`ifdef CORE_SEQ_PERF_EN
      check("stall_stall_cnt", stall_cnt, 2);
      check("stall_cycle_cnt", cycle_cnt, 51);
`endif

      // address wrap
      fill_valid(100);
      run("wrap", 1, 4, 2046, 2045, 0);
      if (xr_addr.size() >= 4) begin
         check("wrap_x0", xr_addr[0], 2046);
         check("wrap_x1", xr_addr[1], 2047);
         check("wrap_x2", xr_addr[2], 0);
         check("wrap_x3", xr_addr[3], 1);
      end else check("wrap_xreads", xr_addr.size(), 12);
      if (pw_addr.size() >= 4) check("wrap_p3", pw_addr[3], 0);

      // start while busy with different cfg must be ignored
      run("restart", 2, 3, 50, 10, 1);
      check("restart_busy_len", busy_cycles, 106);

      // zero counts behave as one
      run("zeros", 0, 0, 7, 9, 0);
      check("zeros_busy_len", busy_cycles, 45);

      // reset in the middle of EXEC
      run("abort", 1, 4, 0, 0, 2);

      // start and reset in the same cycle: reset wins
      @(negedge clk);
      start = 1'b1; reset = 1'b0; cfg_num_kij = 4'd1; cfg_num_act = 11'd4;
      @(negedge clk);
      start = 1'b0; reset = 1'b1;
      repeat (3) @(negedge clk);
      check("startreset_busy", busy, 0);
      check("startreset_inst", inst, IDLE_W);

      // randomized runs with a sporadically empty FIFO
      for (int r = 0; r < 8; r++) begin
         fill_valid(60 + 5 * r);
         run("rand", $urandom_range(1, 9), $urandom_range(1, 6),
             $urandom_range(0, 2047), $urandom_range(0, 2047), 0);
         check("rand_done_width", done_cycles, 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
